sc_stream_decoder: RTL and testbench
====================================

Name: sc_stream_decoder

Overview:
- Receive end of the stochastic-number link: takes a serial stochastic bitstream, one bit per valid cycle, and converts it back to binary.
- Counts the ones over a fixed window of N = 2^WINDOW_LOG2 valid bits.
- Produces either a unipolar count (0..N) or a bipolar signed value (2*ones - N).
- Result leaves on a valid/ready output with overrun detection; sits downstream of the LFSR/comparator encoders and XNOR multipliers.

Parameters:
- WINDOW_LOG2, 8, log2 of the window length N in valid bits; legal range 2..12.
- RES_W, WINDOW_LOG2+2, result width; fixed by the formula, not overridable.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  decoder enable; low = idle, partial window discarded.
- clear  input  1  synchronous abort: flushes window, result and overrun.
- bipolar  input  1  mode, 1 = bipolar, 0 = unipolar; sampled at each window start.
- sn_bit  input  1  stochastic stream bit.
- sn_valid  input  1  sn_bit qualifier; bit counted only when high.
- out_data  output  RES_W  window result; two's complement in bipolar mode, zero-extended in unipolar mode.
- out_valid  output  1  out_data holds an unconsumed result.
- out_ready  input  1  consumer accepts out_data when out_valid && out_ready.
- out_bipolar  output  1  mode the current out_data was computed in.
- overrun  output  1  sticky: a result was overwritten before being taken.
- busy  output  1  high while in ACCUM.

Behaviour:
- Reset (rst_n low, async): state IDLE; out_data=0, out_valid=0, out_bipolar=0, overrun=0, busy=0; bit and ones counters 0.
- Counters:
  - bit_cnt is WINDOW_LOG2 bits wide and wraps naturally.
  - ones_cnt is WINDOW_LOG2+1 bits wide and reaches N without overflow.
- IDLE: counters held at 0; mode_reg <= bipolar. On en=1, next state is ACCUM. sn_valid is ignored in IDLE.
- ACCUM: on each edge with sn_valid=1:
  - bit_cnt increments;
  - ones_cnt increments if sn_bit=1.
- Window complete: the edge where sn_valid=1 and bit_cnt=N-1. On that same edge:
  - out_data is loaded with the total including that last bit; out_valid <= 1; out_bipolar <= mode_reg;
  - counters reset to 0; mode_reg <= bipolar;
  - remain in ACCUM if en=1, else go to IDLE.
  - Latency: result visible one clock after the final bit is presented.
- Result arithmetic:
  - Unipolar: out_data = ones.
  - Bipolar: out_data = (ones<<1) - N, signed RES_W; range -N..+N. All-ones gives +N, all-zeros gives -N, and ones = N/2 gives 0.
- Handshake:
  - out_valid clears on an edge with out_ready=1, unless a new window completes on that same edge. In that case out_valid stays 1 with new data and there is no overrun.
  - out_data is stable while out_valid=1 and no new window completes.
- Overrun: a window completes while out_valid=1 and out_ready=0.
  - New result overwrites out_data and overrun <= 1.
  - overrun stays set until clear or reset.
- en falls mid-window: next edge goes to IDLE and the partial counts are discarded. out_valid and out_data are untouched; a pending result can still be taken.
- clear=1 (any state): takes priority over all other updates.
  - Counters, out_valid and overrun are zeroed; out_data is held.
  - mode_reg <= bipolar.
  - Next state is ACCUM if en=1, else IDLE; a new window starts from bit 0.
- Mode change mid-window: bipolar is not re-sampled until the next window start.

Optional Feature:
- Macro: SC_DEC_INPUT_SYNC_EN.
- Defined: sn_bit and sn_valid each pass through a 2-flop synchronizer (reset to 0) before the counters; end-to-end latency grows by 2 cycles, so out_valid rises 3 clocks after the final bit is presented. The synchronizer flops are not cleared by clear.
- Undefined: inputs are used directly; latency is 1 cycle.

Test Plan (WINDOW_LOG2=3, N=8, feature undefined unless stated):
- Unipolar, out_ready=1:
  - stream 1,0,1,1,0,0,1,0 with sn_valid=1 -> one cycle after the 8th bit: out_data=4, out_valid pulses 1 cycle, out_bipolar=0.
  - All-ones window -> out_data=8.
- Bipolar:
  - all-zeros window -> out_data=-8 (RES_W=5: 5'b11000);
  - 6 ones of 8 -> out_data=+4;
  - 4 ones -> 0.
- Gapped valid: same 8 bits with sn_valid low on alternate cycles -> identical result 4. Completion occurs one cycle after the 8th valid bit, not the 8th cycle.
- Backpressure with out_ready=0:
  - two windows (3 ones, then 5 ones) -> out_data=5, overrun=1 after the second;
  - out_ready=1 for one cycle -> out_valid=0, overrun stays 1;
  - clear -> overrun=0.
- Simultaneous: out_ready=1 on the completion edge of the next window -> out_valid stays 1, new data, overrun=0.
- Abort and reset:
  - en dropped after 5 bits, re-raised, 8 more bits -> result counts only the last 8;
  - rst_n pulsed low mid-window, asynchronously -> all outputs 0 immediately.
- With SC_DEC_INPUT_SYNC_EN: unipolar case repeated -> out_data=4, out_valid 3 cycles after the final bit.

Source files
------------

// File: rtl/sc_stream_decoder.sv
// sc_stream_decoder
//   Receive end of a stochastic-number link. Counts the ones in a serial
//   bitstream over a window of N = 2**WINDOW_LOG2 valid bits and returns the
//   result as a unipolar count (0..N) or as a bipolar signed value
//   (2*ones - N). The result is presented on a valid/ready output, and a
//   sticky flag records any result that was overwritten before it was taken.
//
//   Optional build macro: SC_DEC_INPUT_SYNC_EN
//     Defined   : sn_bit/sn_valid pass through 2-flop synchronizers
//                 (reset to 0, not affected by clear); latency is 3 clocks.
//     Undefined : inputs feed the counters directly; latency is 1 clock.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   en           decoder enable; dropping it discards the partial window
//   clear        synchronous abort: flushes window, out_valid and overrun
//   bipolar      output mode, sampled at each window start
//   sn_bit       stochastic stream bit
//   sn_valid     qualifier for sn_bit
//   out_data     window result (RES_W = WINDOW_LOG2+2 bits)
//   out_valid    out_data holds an unconsumed result
//   out_ready    consumer accepts out_data when out_valid && out_ready
//   out_bipolar  mode the current out_data was computed in
//   overrun      sticky: a result was overwritten before being taken
//   busy         high while accumulating
module sc_stream_decoder #(
  parameter int unsigned WINDOW_LOG2 = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   clear,
  input  logic                   bipolar,
  input  logic                   sn_bit,
  input  logic                   sn_valid,
  output logic [WINDOW_LOG2+1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_bipolar,
  output logic                   overrun,
  output logic                   busy
);

  localparam int unsigned RES_W = WINDOW_LOG2 + 2;
  localparam int unsigned N     = 1 << WINDOW_LOG2;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ACCUM = 1'b1;

  logic                   bit_in;
  logic                   val_in;

`ifdef SC_DEC_INPUT_SYNC_EN
  logic [1:0] bit_sync_q;
  logic [1:0] val_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_sync_q <= '0;
      val_sync_q <= '0;
    end else begin
      bit_sync_q <= {bit_sync_q[0], sn_bit};
      val_sync_q <= {val_sync_q[0], sn_valid};
    end
  end

  assign bit_in = bit_sync_q[1];
  assign val_in = val_sync_q[1];
`else
  assign bit_in = sn_bit;
  assign val_in = sn_valid;
`endif

  logic [0:0]             state_q,   state_d;
  logic [WINDOW_LOG2-1:0] bit_cnt_q, bit_cnt_d;
  logic [WINDOW_LOG2:0]   ones_q,    ones_d;
  logic                   mode_q,    mode_d;
  logic [RES_W-1:0]       data_q,    data_d;
  logic                   valid_q,   valid_d;
  logic                   obip_q,    obip_d;
  logic                   ovr_q,     ovr_d;

  logic [WINDOW_LOG2:0]   ones_tot;
  logic                   win_done;
  logic [RES_W-1:0]       result;

  // Total including the bit on this edge, so the last bit of a window is
  // folded into the result on the same edge that completes it.
  assign ones_tot = ones_q + {{WINDOW_LOG2{1'b0}}, bit_in & val_in};
  assign win_done = (state_q == S_ACCUM) && val_in && (bit_cnt_q == '1);
  assign result   = mode_q ? ({ones_tot, 1'b0} - RES_W'(N))
                           : {1'b0, ones_tot};

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    ones_d    = ones_q;
    mode_d    = mode_q;
    data_d    = data_q;
    valid_d   = valid_q;
    obip_d    = obip_q;
    ovr_d     = ovr_q;

    if (clear) begin
      bit_cnt_d = '0;
      ones_d    = '0;
      valid_d   = 1'b0;
      ovr_d     = 1'b0;
      mode_d    = bipolar;
      state_d   = en ? S_ACCUM : S_IDLE;
    end else begin
      if (valid_q && out_ready) begin
        valid_d = 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          bit_cnt_d = '0;
          ones_d    = '0;
          mode_d    = bipolar;
          if (en) begin
            state_d = S_ACCUM;
          end
        end

        default: begin
          // A completing window is delivered even if en drops on that edge.
          if (win_done) begin
            data_d    = result;
            valid_d   = 1'b1;
            obip_d    = mode_q;
            if (valid_q && !out_ready) begin
              ovr_d = 1'b1;
            end
            bit_cnt_d = '0;
            ones_d    = '0;
            mode_d    = bipolar;
            state_d   = en ? S_ACCUM : S_IDLE;
          end else if (!en) begin
            bit_cnt_d = '0;
            ones_d    = '0;
            state_d   = S_IDLE;
          end else if (val_in) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            ones_d    = ones_tot;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      ones_q    <= '0;
      mode_q    <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      obip_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      ones_q    <= ones_d;
      mode_q    <= mode_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      obip_q    <= obip_d;
      ovr_q     <= ovr_d;
    end
  end

  assign out_data    = data_q;
  assign out_valid   = valid_q;
  assign out_bipolar = obip_q;
  assign overrun     = ovr_q;
  assign busy        = (state_q == S_ACCUM);

endmodule

// File: tb/tb_sc_stream_decoder.sv
// Directed testbench for sc_stream_decoder with WINDOW_LOG2=3 (N=8, RES_W=5).
module tb_sc_stream_decoder;

`ifdef SC_DEC_INPUT_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       clear;
  logic       bipolar;
  logic       sn_bit;
  logic       sn_valid;
  logic [4:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_bipolar;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int errors = 0;

  sc_stream_decoder #(.WINDOW_LOG2(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .clear       (clear),
    .bipolar     (bipolar),
    .sn_bit      (sn_bit),
    .sn_valid    (sn_valid),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_bipolar (out_bipolar),
    .overrun     (overrun),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents 8 valid bits MSB first, then pads so the result is visible.
  task automatic feed(input logic [7:0] bits, input bit gapped);
    for (int i = 0; i < 8; i++) begin
      sn_bit   = bits[7-i];
      sn_valid = 1'b1;
      step();
      if (gapped && i < 7) begin
        sn_valid = 1'b0;
        sn_bit   = ~sn_bit;
        step();
      end
    end
    sn_valid = 1'b0;
    sn_bit   = 1'b0;
    for (int i = 1; i < LAT; i++) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; clear = 1'b0; bipolar = 1'b0;
    sn_bit = 1'b0; sn_valid = 1'b0; out_ready = 1'b0;
    step(); step();
    checks++; if (out_data !== 5'd0) begin errors++; $display("FAIL rst_data: got %0d expected 0", out_data); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
    checks++; if (out_bipolar !== 1'b0) begin errors++; $display("FAIL rst_bipolar: got %b expected 0", out_bipolar); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun: got %b expected 0", overrun); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_unipolar();
    out_ready = 1'b1; bipolar = 1'b0; en = 1'b1;
    step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL uni_busy: got %b expected 1", busy); end
    feed(8'b1011_0010, 1'b0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL uni_valid: got %b expected 1", out_valid); end
    checks++; if (out_data !== 5'd4) begin errors++; $display("FAIL uni_data: got %0d expected 4", out_data); end
    checks++; if (out_bipolar !== 1'b0) begin errors++; $display("FAIL uni_mode: got %b expected 0", out_bipolar); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL uni_pulse: got %b expected 0", out_valid); end
    checks++; if (out_data !== 5'd4) begin errors++; $display("FAIL uni_hold: got %0d expected 4", out_data); end
    feed(8'b1111_1111, 1'b0);
    checks++; if (out_data !== 5'd8) begin errors++; $display("FAIL uni_all_ones: got %0d expected 8", out_data); end
  endtask

  task automatic test_bipolar();
    en = 1'b0;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bip_idle: got %b expected 0", busy); end
    bipolar = 1'b1; en = 1'b1;
    step();
    feed(8'b0000_0000, 1'b0);
    checks++; if (out_data !== 5'b11000) begin errors++; $display("FAIL bip_zeros: got %b expected 11000", out_data); end
    checks++; if (out_bipolar !== 1'b1) begin errors++; $display("FAIL bip_mode: got %b expected 1", out_bipolar); end
    feed(8'b1111_1100, 1'b0);
    checks++; if (out_data !== 5'd4) begin errors++; $display("FAIL bip_six: got %0d expected 4", out_data); end
    feed(8'b1111_0000, 1'b0);
    checks++; if (out_data !== 5'd0) begin errors++; $display("FAIL bip_half: got %0d expected 0", out_data); end
  endtask

  task automatic test_mode_midwindow();
    logic [7:0] bits;
    bits = 8'b1100_1100;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) bipolar = 1'b0;
      sn_bit = bits[7-i]; sn_valid = 1'b1;
      step();
    end
    sn_valid = 1'b0; sn_bit = 1'b0;
    for (int i = 1; i < LAT; i++) step();
    checks++; if (out_data !== 5'd0) begin errors++; $display("FAIL mid_data: got %0d expected 0", out_data); end
    checks++; if (out_bipolar !== 1'b1) begin errors++; $display("FAIL mid_mode: got %b expected 1", out_bipolar); end
    feed(8'b1100_1100, 1'b0);
    checks++; if (out_data !== 5'd4) begin errors++; $display("FAIL mid_next_data: got %0d expected 4", out_data); end
    checks++; if (out_bipolar !== 1'b0) begin errors++; $display("FAIL mid_next_mode: got %b expected 0", out_bipolar); end
  endtask

  task automatic test_gapped();
    logic [7:0] bits;
    bits = 8'b1011_0010;
    for (int i = 0; i < 8; i++) begin
      sn_bit = bits[7-i]; sn_valid = 1'b1;
      if (i == 7) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL gap_early: got %b expected 0", out_valid); end
      end
      step();
      if (i < 7) begin
        sn_valid = 1'b0; sn_bit = ~sn_bit;
        step();
      end
    end
    sn_valid = 1'b0; sn_bit = 1'b0;
    for (int i = 1; i < LAT; i++) step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL gap_valid: got %b expected 1", out_valid); end
    checks++; if (out_data !== 5'd4) begin errors++; $display("FAIL gap_data: got %0d expected 4", out_data); end
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    feed(8'b1110_0000, 1'b0);
    checks++; if (out_data !== 5'd3) begin errors++; $display("FAIL bp_first: got %0d expected 3", out_data); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL bp_no_ovr: got %b expected 0", overrun); end
    feed(8'b1111_1000, 1'b0);
    checks++; if (out_data !== 5'd5) begin errors++; $display("FAIL bp_second: got %0d expected 5", out_data); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL bp_ovr: got %b expected 1", overrun); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_taken: got %b expected 0", out_valid); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL bp_sticky: got %b expected 1", overrun); end
    clear = 1'b1;
    step();
    clear = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL bp_clear: got %b expected 0", overrun); end
    checks++; if (out_data !== 5'd5) begin errors++; $display("FAIL bp_clear_hold: got %0d expected 5", out_data); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_clear_busy: got %b expected 1", busy); end
  endtask

  task automatic test_simultaneous();
    logic [7:0] bits;
    out_ready = 1'b0;
    feed(8'b1110_0000, 1'b0);
    bits = 8'b1010_1011;
    for (int i = 0; i < 8 + LAT - 1; i++) begin
      sn_valid  = (i < 8);
      sn_bit    = (i < 8) ? bits[7-i] : 1'b0;
      out_ready = (i == 8 + LAT - 2);
      step();
    end
    sn_valid = 1'b0; sn_bit = 1'b0; out_ready = 1'b1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sim_valid: got %b expected 1", out_valid); end
    checks++; if (out_data !== 5'd5) begin errors++; $display("FAIL sim_data: got %0d expected 5", out_data); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL sim_ovr: got %b expected 0", overrun); end
    step();
  endtask

  task automatic test_abort();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sn_bit = 1'b1; sn_valid = 1'b1;
      step();
    end
    sn_valid = 1'b0; sn_bit = 1'b0;
    for (int i = 1; i < LAT; i++) step();
    en = 1'b0;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle: got %b expected 0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_no_result: got %b expected 0", out_valid); end
    en = 1'b1;
    step();
    feed(8'b1000_0001, 1'b0);
    checks++; if (out_data !== 5'd2) begin errors++; $display("FAIL abort_data: got %0d expected 2", out_data); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    feed(8'b1000_0001, 1'b0);
    for (int i = 0; i < 3; i++) begin
      sn_bit = 1'b1; sn_valid = 1'b1;
      step();
    end
    sn_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_data !== 5'd0) begin errors++; $display("FAIL arst_data: got %0d expected 0", out_data); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b expected 0", out_valid); end
    checks++; if (out_bipolar !== 1'b0) begin errors++; $display("FAIL arst_mode: got %b expected 0", out_bipolar); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b expected 0", busy); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL arst_ovr: got %b expected 0", overrun); end
    #1 rst_n = 1'b1;
    out_ready = 1'b1; en = 1'b1; bipolar = 1'b0;
    step();
    feed(8'b0101_0101, 1'b0);
    checks++; if (out_data !== 5'd4) begin errors++; $display("FAIL arst_restart: got %0d expected 4", out_data); end
  endtask

  initial begin
    test_reset();
    test_unipolar();
    test_bipolar();
    test_mode_midwindow();
    test_gapped();
    test_backpressure();
    test_simultaneous();
    test_abort();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule
